// File: rtl/async_4bit_pkg.sv
// async_4bit_pkg: shared width, count type and default reset value for the 4-bit counter
package async_4bit_pkg;
    localparam int CNT_W = 4;
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t DEFAULT_RESET_VALUE = 4'h0;
endpackage

// File: rtl/async_4bit_t_ff_stage.sv
// t_ff_stage: one toggle stage of the counter; carry_en enables the next stage on its 1->0 edge
module t_ff_stage (
    input  logic clk,
    input  logic rst_n,
    input  logic rst_val,
    input  logic t_en,
    output logic q,
    output logic carry_en
);
    always_ff @(posedge clk)
        if (!rst_n) q <= rst_val;
        else if (t_en) q <= ~q;
    assign carry_en = t_en & q;
endmodule

// File: rtl/async_4bit.sv
// async_4bit: single-clock ripple-order 4-bit up-counter; ASYNC4_TC_EN adds the terminal-count output TC
module async_4bit
    import async_4bit_pkg::*;
#(
    parameter cnt_t RESET_VALUE = DEFAULT_RESET_VALUE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic T,
    output logic Q0,
    output logic Q1,
    output logic Q2,
    output logic Q3
`ifdef ASYNC4_TC_EN
    ,
    output logic TC
`endif
);
    logic [CNT_W:0]   en;
    logic [CNT_W-1:0] q;
    assign en[0] = T;
    genvar i;
    generate
        for (i = 0; i < CNT_W; i++) begin : g_stage
            t_ff_stage u_stage (
                .clk      (clk),
                .rst_n    (rst_n),
                .rst_val  (RESET_VALUE[i]),
                .t_en     (en[i]),
                .q        (q[i]),
                .carry_en (en[i+1])
            );
        end
    endgenerate
    assign Q0 = q[0];
    assign Q1 = q[1];
    assign Q2 = q[2];
    assign Q3 = q[3];
`ifdef ASYNC4_TC_EN
    // the final carry is exactly (Q == 4'hF) && T
    assign TC = en[CNT_W];
`else
    logic tc_unused;
    assign tc_unused = en[CNT_W];
`endif
endmodule

// File: tb/tb_async_4bit.sv
// tb_async_4bit: table-driven scoreboard bench for async_4bit (TC checks when ASYNC4_TC_EN is defined)
module tb_async_4bit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic T = 1'b0;
    logic Q0, Q1, Q2, Q3;
`ifdef ASYNC4_TC_EN
    logic TC;
`endif
    int errors = 0;
    int checks = 0;
    logic [3:0] sb[$];
    logic [3:0] cur = 4'h0;
    bit valid = 1'b0;

    typedef struct {
        logic r;
        logic t;
        logic [3:0] e;
    } vec_t;
    vec_t tbl[$];

    always #10 clk = ~clk;

    async_4bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .T     (T),
        .Q0    (Q0),
        .Q1    (Q1),
        .Q2    (Q2),
        .Q3    (Q3)
`ifdef ASYNC4_TC_EN
        ,
        .TC    (TC)
`endif
    );

    task automatic cyc(input logic r, input logic t, input logic [3:0] e, input string name);
        logic [3:0] got, want;
        rst_n = r;
        T = t;
        sb.push_back(e);
`ifdef ASYNC4_TC_EN
        #1;
        if (valid) begin
            checks++;
            if (TC !== ((cur == 4'hF) && t)) begin
                errors++;
                $display("FAIL tc_%s got=%b exp=%b (count=%h T=%b)", name, TC, (cur == 4'hF) && t, cur, t);
            end
        end
`endif
        @(posedge clk);
        #1;
        got = {Q3, Q2, Q1, Q0};
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_%s scoreboard empty got=%h", name, got);
        end else begin
            want = sb.pop_front();
            if (got !== want) begin
                errors++;
                $display("FAIL q_%s got=%h exp=%h", name, got, want);
            end
        end
        cur = e;
        valid = 1'b1;
    endtask

    initial begin
        // hold at 5, resume, ripple 0111->1000, reset at 1011, release
        tbl.push_back('{1'b1, 1'b1, 4'h1});
        tbl.push_back('{1'b1, 1'b1, 4'h2});
        tbl.push_back('{1'b1, 1'b1, 4'h3});
        tbl.push_back('{1'b1, 1'b1, 4'h4});
        tbl.push_back('{1'b1, 1'b1, 4'h5});
        tbl.push_back('{1'b1, 1'b0, 4'h5});
        tbl.push_back('{1'b1, 1'b0, 4'h5});
        tbl.push_back('{1'b1, 1'b0, 4'h5});
        tbl.push_back('{1'b1, 1'b0, 4'h5});
        tbl.push_back('{1'b1, 1'b1, 4'h6});
        tbl.push_back('{1'b1, 1'b1, 4'h7});
        tbl.push_back('{1'b1, 1'b1, 4'h8});
        tbl.push_back('{1'b1, 1'b1, 4'h9});
        tbl.push_back('{1'b1, 1'b1, 4'hA});
        tbl.push_back('{1'b1, 1'b1, 4'hB});
        tbl.push_back('{1'b0, 1'b1, 4'h0});
        tbl.push_back('{1'b1, 1'b1, 4'h1});

        cyc(1'b0, 1'b1, 4'h0, "reset0");
        cyc(1'b0, 1'b1, 4'h0, "reset1");
        for (int i = 1; i <= 16; i++) cyc(1'b1, 1'b1, 4'(i), "free");
        for (int i = 0; i < tbl.size(); i++) cyc(tbl[i].r, tbl[i].t, tbl[i].e, "table");
        for (int i = 2; i <= 15; i++) cyc(1'b1, 1'b1, 4'(i), "to_f");
        cyc(1'b1, 1'b0, 4'hF, "hold_f");
        cyc(1'b1, 1'b1, 4'h0, "wrap");
        cyc(1'b1, 1'b0, 4'h0, "hold_0");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
